// File: rtl/cfg_shift_bank.sv
// Serial config shift chain: sde_in shifts, dl_in commits a full frame to cfg_out one cycle later. No backpressure.
// Readback (ul_in reload, sd_out = chain MSB) is compiled in only when CFG_READBACK_EN is defined.
module cfg_shift_bank #(
   parameter int                     CFG_BYTES = 4,
   parameter logic [CFG_BYTES*8-1:0] CFG_INIT  = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sde_in,
   input  logic                   sd_in,
   input  logic                   ul_in,
   input  logic                   dl_in,
   output logic                   sd_out,
   output logic [CFG_BYTES*8-1:0] cfg_out,
   output logic                   cfg_valid_out,
   output logic                   err_out
);

   localparam int N  = CFG_BYTES * 8;
   localparam int CW = $clog2(N + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(N);
   localparam logic [CW-1:0] CNT_SAT  = CW'(N + 1);

   typedef enum logic [1:0] {EMPTY, FILL, FULL, OVER} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    chain_q, chain_d;
   logic [N-1:0]    cfg_q, cfg_d;
   logic            vld_q, vld_d;
   logic            err_q, err_d;
   logic            ul_en;

`ifdef CFG_READBACK_EN
   assign ul_en  = ul_in;
   assign sd_out = chain_q[N-1];
`else
   logic unused_ul;
   assign unused_ul = ul_in;
   assign ul_en     = 1'b0;
   assign sd_out    = 1'b0;
`endif

   assign cfg_out       = cfg_q;
   assign cfg_valid_out = vld_q;
   assign err_out       = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
         chain_q <= '0;
         cfg_q   <= CFG_INIT;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chain_q <= chain_d;
         cfg_q   <= cfg_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   // dl_in outranks ul_in, which outranks sde_in; the losers are dropped.
   always_comb begin
      chain_d = chain_q;
      cnt_d   = cnt_q;
      cfg_d   = cfg_q;
      vld_d   = 1'b0;
      err_d   = err_q;
      state_d = state_q;

      if (dl_in) begin
         cnt_d = '0;
         if (state_q == FULL) begin
            cfg_d = chain_q;
            vld_d = 1'b1;
            err_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else if (ul_en) begin
         chain_d = cfg_q;
         cnt_d   = '0;
      end else if (sde_in) begin
         chain_d = {chain_q[N-2:0], sd_in};
         if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (cnt_d == '0) begin
         state_d = EMPTY;
      end else if (cnt_d < CNT_FULL) begin
         state_d = FILL;
      end else if (cnt_d == CNT_FULL) begin
         state_d = FULL;
      end else begin
         state_d = OVER;
      end
   end

endmodule

// File: tb/tb_cfg_shift_bank.sv
// Directed and randomized frames against a word-level model of the config bank.
module tb_cfg_shift_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sde_in = 1'b0, sd_in = 1'b0, ul_in = 1'b0, dl_in = 1'b0;
   logic        sd_out, cfg_valid_out, err_out;
   logic [31:0] cfg_out;

   int checks = 0;
   int errors = 0;

`ifdef CFG_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   // Reference model: the chain as a 32-bit word, count as a plain integer.
   logic [31:0] m_chain, m_cfg;
   int          m_cnt;
   bit          m_vld, m_err;
   bit          last_vld_obs;

   cfg_shift_bank #(.CFG_BYTES(4), .CFG_INIT(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .sde_in(sde_in), .sd_in(sd_in), .ul_in(ul_in), .dl_in(dl_in),
      .sd_out(sd_out), .cfg_out(cfg_out), .cfg_valid_out(cfg_valid_out), .err_out(err_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_chain = 32'h0; m_cfg = 32'h0; m_cnt = 0; m_vld = 1'b0; m_err = 1'b0;
      last_vld_obs = 1'b0;
   endtask

   task automatic check_all();
      chk("sd_out", {31'b0, sd_out}, {31'b0, RB ? m_chain[31] : 1'b0});
      chk("cfg_out", cfg_out, m_cfg);
      chk("cfg_valid_out", {31'b0, cfg_valid_out}, {31'b0, m_vld});
      chk("err_out", {31'b0, err_out}, {31'b0, m_err});
   endtask

   task automatic cycle(input bit sde, input bit sd, input bit ul, input bit dl);
      sde_in = sde; sd_in = sd; ul_in = ul; dl_in = dl;
      @(posedge clk);
      m_vld = 1'b0;
      if (dl) begin
         if (m_cnt == 32) begin
            m_cfg = m_chain; m_vld = 1'b1; m_err = 1'b0;
         end else begin
            m_err = 1'b1;
         end
         m_cnt = 0;
      end else if (ul && RB) begin
         m_chain = m_cfg; m_cnt = 0;
      end else if (sde) begin
         m_chain = (m_chain << 1) | 32'(sd);
         m_cnt   = (m_cnt >= 33) ? 33 : m_cnt + 1;
      end
      #1;
      sde_in = 1'b0; ul_in = 1'b0; dl_in = 1'b0;
      check_all();
      if (last_vld_obs) chk("valid_not_twice", {31'b0, cfg_valid_out}, 32'h0);
      last_vld_obs = cfg_valid_out;
   endtask

   // Shift nbits of w MSB-first; bits past 32 are random.
   task automatic shift_word(input logic [31:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         cycle(1'b1, (i < 32) ? w[31-i] : 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [31:0] w;
      int          len;
      model_reset();
      #3;
      chk("reset_cfg_out", cfg_out, 32'h0000_0000);
      chk("reset_sd_out", {31'b0, sd_out}, 32'h0);
      chk("reset_err_out", {31'b0, err_out}, 32'h0);
      chk("reset_valid", {31'b0, cfg_valid_out}, 32'h0);
      rst_n = 1'b1;

      // Exact frame commits one cycle after dl_in, valid for one cycle only.
      shift_word(32'hA5C3_0F81, 32);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("commit_cfg", cfg_out, 32'hA5C3_0F81);
      chk("commit_valid", {31'b0, cfg_valid_out}, 32'h1);
      chk("commit_err", {31'b0, err_out}, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("commit_valid_drop", {31'b0, cfg_valid_out}, 32'h0);

      // Readback of the committed word, MSB-first.
      w = 32'hA5C3_0F81;
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("ul_sd_out", {31'b0, sd_out}, {31'b0, RB ? 1'b1 : 1'b0});
      for (int i = 0; i < 31; i++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         chk("readback_bit", {31'b0, sd_out}, {31'b0, RB ? w[30-i] : 1'b0});
      end

      // Short frame rejected, then a good frame clears the error.
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      shift_word($urandom, 31);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("short_cfg", cfg_out, 32'hA5C3_0F81);
      chk("short_valid", {31'b0, cfg_valid_out}, 32'h0);
      chk("short_err", {31'b0, err_out}, 32'h1);
      shift_word(32'h1234_5678, 32);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("recover_cfg", cfg_out, 32'h1234_5678);
      chk("recover_err", {31'b0, err_out}, 32'h0);

      // Long frame rejected.
      shift_word($urandom, 33);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("long_err", {31'b0, err_out}, 32'h1);
      chk("long_cfg", cfg_out, 32'h1234_5678);

      // All three strobes at a full count: commit wins, chain untouched.
      w = 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
      shift_word(w, 32);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      chk("prio_cfg", cfg_out, w);
      chk("prio_valid", {31'b0, cfg_valid_out}, 32'h1);
      chk("prio_chain_msb", {31'b0, sd_out}, {31'b0, RB ? 1'b1 : 1'b0});
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      if (!RB) chk("ul_ignored_sd_out", {31'b0, sd_out}, 32'h0);

      // Reset in the middle of a frame discards partial data.
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      shift_word($urandom, 10);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midreset_cfg", cfg_out, 32'h0);
      chk("midreset_sd_out", {31'b0, sd_out}, 32'h0);
      chk("midreset_err", {31'b0, err_out}, 32'h0);
      chk("midreset_valid", {31'b0, cfg_valid_out}, 32'h0);
      #1 rst_n = 1'b1;
      w = $urandom;
      shift_word(w, 32);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("post_reset_cfg", cfg_out, w);

      // Randomized frames with gaps, readbacks and colliding strobes.
      for (int f = 0; f < 40; f++) begin
         w   = $urandom;
         len = ($urandom_range(0, 1) == 1) ? 32 : int'($urandom_range(29, 35));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, (i < 32) ? w[31-i] : 1'b1, 1'b0, 1'b0);
         end
         case ($urandom_range(0, 4))
            0:       cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            1:       cycle(1'b0, 1'b0, 1'b1, 1'b0);
            2:       cycle(1'b1, 1'b1, 1'b1, 1'b0);
            default: cycle(1'b0, 1'b0, 1'b0, 1'b1);
         endcase
         cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
